// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM encoding,
// register-index constants and the bundled control-output word.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic hold;
    } ctrl_t;

    // Pipeline advances freely / everything frozen behind the PC.
    localparam ctrl_t CTRL_RUN  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_HOLD = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/hazard_ctrl_event_counter.sv
// Free-running event counter with synchronous clear; wraps modulo 2^CNT_W.
module event_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// data-memory wait handling with a sticky timeout, plus stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_memread,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
    ctrl_t             ctrl;
    logic              memhaz, taken, loaduse;

    assign memhaz  = (exmem_memread | exmem_memwrite) & ~dmem_ready;
    assign taken   = exmem_branch & exmem_zero;
    assign loaduse = idex_memread & (idex_rd != REG_X0) &
                     ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            mem_timeout <= mem_timeout | (state_next == TIMEOUT);
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        unique case (state)
            RUN: begin
                if (memhaz) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = '0;
                end
            end
            MEM_WAIT: begin
                if (!memhaz) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else begin
                    // The wait that brings the count to MAX_WAIT is the last one allowed.
                    wait_cnt_next = wait_cnt + WAIT_W'(1);
                    if (wait_cnt_next == WAIT_W'(MAX_WAIT))
                        state_next = TIMEOUT;
                end
            end
            TIMEOUT:  state_next = TIMEOUT;
            default:  state_next = RUN;
        endcase
    end

    always_comb begin
        ctrl = CTRL_RUN;
        if (reset) begin
            ctrl = CTRL_HOLD;
        end else if (state == TIMEOUT) begin
            ctrl = CTRL_HOLD;
        end else if (memhaz) begin
            ctrl = CTRL_HOLD;
        end else if (taken) begin
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
        end else if (loaduse) begin
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_write = 1'b0;
            ctrl.idex_flush = 1'b1;
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;
    assign hold        = ctrl.hold;

    event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~ctrl.pc_write),
        .count (stall_count)
    );

    event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl.exmem_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus hand-written
// memory-wait, timeout and reset sequences, compared through a scoreboard queue.
module tb_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 32;

    logic             clk;
    logic             reset;
    logic [4:0]       ifid_rs1, ifid_rs2, idex_rd;
    logic             idex_memread, exmem_branch, exmem_zero;
    logic             exmem_memread, exmem_memwrite, dmem_ready;
    logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, hold;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count, flush_count;

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .ifid_rs1       (ifid_rs1),
        .ifid_rs2       (ifid_rs2),
        .idex_rd        (idex_rd),
        .idex_memread   (idex_memread),
        .exmem_branch   (exmem_branch),
        .exmem_zero     (exmem_zero),
        .exmem_memread  (exmem_memread),
        .exmem_memwrite (exmem_memwrite),
        .dmem_ready     (dmem_ready),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_flush    (exmem_flush),
        .hold           (hold),
        .mem_timeout    (mem_timeout),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       idex_mr;
        logic       br;
        logic       zero;
        logic       mr;
        logic       mw;
        logic       ready;
    } in_t;

    // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, hold, mem_timeout}
    typedef logic [6:0] out_t;

    typedef struct {
        in_t  in;
        out_t want;
    } vec_t;

    localparam out_t O_RUN   = 7'b1100000;
    localparam out_t O_LU    = 7'b0001000;
    localparam out_t O_FLUSH = 7'b1111100;
    localparam out_t O_HOLD  = 7'b0000010;
    localparam out_t O_TO    = 7'b0000011;

    int               checks = 0;
    int               errors = 0;
    out_t             exp_q[$];
    logic [CNT_W-1:0] m_stall;
    logic [CNT_W-1:0] m_flush;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic idex_mr,
                               input logic br, input logic zero, input logic mr,
                               input logic mw, input logic ready);
        in_t v;
        v = '{rs1, rs2, rd, idex_mr, br, zero, mr, mw, ready};
        return v;
    endfunction

    function automatic out_t got_out();
        return {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, hold, mem_timeout};
    endfunction

    // One clock cycle: drive, queue the expectation, compare at the falling edge,
    // then advance the counter model by what this cycle should contribute.
    task automatic step(input string name, input in_t in, input logic rst, input out_t want);
        out_t e;
        {ifid_rs1, ifid_rs2, idex_rd, idex_memread, exmem_branch, exmem_zero,
         exmem_memread, exmem_memwrite, dmem_ready} = in;
        reset = rst;
        exp_q.push_back(want);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check({name, " outputs"}, 64'(got_out()), 64'(e));
        end
        check({name, " stall_count"}, 64'(stall_count), 64'(m_stall));
        check({name, " flush_count"}, 64'(flush_count), 64'(m_flush));
        if (rst) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (!want[6]) m_stall = m_stall + 1;
            if (want[2])  m_flush = m_flush + 1;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[13];
    in_t  idle, mem_stall, mem_done;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle      = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        mem_stall = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        mem_done  = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        //                  rs1    rs2    rd    idmr  br    zero  mr    mw    ready
        vecs[0]  = '{mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_RUN};
        vecs[1]  = '{mk(5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_LU};
        vecs[2]  = '{mk(5'd7, 5'd9, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_LU};
        vecs[3]  = '{mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_RUN};
        vecs[4]  = '{mk(5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_RUN};
        vecs[5]  = '{mk(5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_RUN};
        vecs[6]  = '{mk(5'd3, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1), O_FLUSH};
        vecs[7]  = '{mk(5'd3, 5'd4, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), O_RUN};
        vecs[8]  = '{mk(5'd3, 5'd4, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), O_RUN};
        vecs[9]  = '{mk(5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), O_HOLD};
        vecs[10] = '{mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1), O_FLUSH};
        vecs[11] = '{mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), O_HOLD};
        vecs[12] = '{mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_RUN};

        m_stall = '0;
        m_flush = '0;
        {ifid_rs1, ifid_rs2, idex_rd, idex_memread, exmem_branch, exmem_zero,
         exmem_memread, exmem_memwrite, dmem_ready} = idle;
        reset = 1'b1;
        @(posedge clk);
        #1;

        step("reset0", idle, 1'b1, O_HOLD);
        step("reset1", idle, 1'b1, O_HOLD);
        check("reset state", 64'(dut.state), 64'd0);
        check("reset wait_cnt", 64'(dut.wait_cnt), 64'd0);

        for (int i = 0; i < 13; i++)
            step($sformatf("vec%0d", i), vecs[i].in, 1'b0, vecs[i].want);

        // Three cycles waiting on memory, then the access completes.
        step("memwait1", mem_stall, 1'b0, O_HOLD);
        check("memwait state", 64'(dut.state), 64'd1);
        step("memwait2", mem_stall, 1'b0, O_HOLD);
        step("memwait3", mem_stall, 1'b0, O_HOLD);
        step("memwait4", mem_done, 1'b0, O_RUN);
        check("memwait back to RUN", 64'(dut.state), 64'd0);
        step("memwait idle", idle, 1'b0, O_RUN);

        // Timeout: one RUN cycle plus MAX_WAIT waiting cycles, then sticky TIMEOUT.
        step("to reset", idle, 1'b1, O_HOLD);
        for (int i = 0; i < MAX_WAIT + 1; i++)
            step($sformatf("to wait%0d", i), mem_stall, 1'b0, O_HOLD);
        step("to stuck0", mem_stall, 1'b0, O_TO);
        check("to state", 64'(dut.state), 64'd2);
        step("to stuck ready", mem_done, 1'b0, O_TO);
        step("to stuck branch", mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0, O_TO);
        step("to clear", idle, 1'b1, O_TO);
        step("to after reset", idle, 1'b0, O_RUN);
        check("to state after reset", 64'(dut.state), 64'd0);

        // Reset arriving in the second waiting cycle.
        step("mid run", mem_stall, 1'b0, O_HOLD);
        step("mid wait1", mem_stall, 1'b0, O_HOLD);
        step("mid wait2 reset", mem_stall, 1'b1, O_HOLD);
        check("mid state", 64'(dut.state), 64'd0);
        check("mid wait_cnt", 64'(dut.wait_cnt), 64'd0);
        step("mid idle", idle, 1'b0, O_RUN);

        @(negedge clk);
        check("final stall_count", 64'(stall_count), 64'(m_stall));
        check("final flush_count", 64'(flush_count), 64'(m_flush));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
